uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_fifo.sv | 67 ++++++
 rtl/uart_transmitter.sv | 139 +++++++++++++
 tb/tb_uart_transmitter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : state encodings and default timing shared by the UART blocks
// Rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned c_default_clk_freq = 100_000_000;
  localparam int unsigned c_default_baud     = 9600;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t c_st_idle  = 2'd0;
  localparam uart_state_t c_st_start = 2'd1;
  localparam uart_state_t c_st_data  = 2'd2;
  localparam uart_state_t c_st_stop  = 2'd3;

  // Cycles per bit; integer division truncates toward zero.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_fifo : small power-of-two FIFO with registered full flag
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned       c_aw       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_aw:0]     c_full_cnt = (c_aw + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [c_aw-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [c_aw:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             w_push, w_pop;

  // Full is a flop, so a pop on the same edge cannot open room for a push.
  assign w_push = push & ~full_q;
  assign w_pop  = pop & (cnt_q != '0);

  always_comb begin
    wr_d = w_push ? wr_q + 1'b1 : wr_q;
    rd_d = w_pop  ? rd_q + 1'b1 : rd_q;
    unique case ({w_push, w_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    full_d = (cnt_d == c_full_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign full  = full_q;
  assign empty = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_transmitter : buffered 8N1 UART transmitter
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = c_default_clk_freq,
  parameter int unsigned BAUD       = c_default_baud,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       UART_TX,
  output logic       tx_busy
);

  localparam int unsigned          c_div      = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned          c_cnt_w    = (c_div > 1) ? $clog2(c_div) : 1;
  localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(c_div - 1);

  uart_state_t        state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;

  logic               w_push, w_pop, w_full, w_empty, w_bit_end;
  logic [7:0]         w_fifo_dout;

  assign w_push    = tx_valid & ~w_full;
  assign w_bit_end = (cnt_q == c_cnt_last);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (sysclk),
    .rst_n (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (tx_data),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q <= c_st_idle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle:  if (!w_empty) state_d = c_st_start;
      c_st_start: if (w_bit_end) state_d = c_st_data;
      c_st_data:  if (w_bit_end && bit_q == 3'd7) state_d = c_st_stop;
      c_st_stop:  if (w_bit_end) state_d = w_empty ? c_st_idle : c_st_start;
      default:    state_d = c_st_idle;
    endcase
  end

  // The line level for the next bit is computed here and registered in tx_q.
  always_comb begin
    cnt_d   = w_bit_end ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    w_pop   = 1'b0;
    case (state_q)
      c_st_idle: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!w_empty) begin
          w_pop   = 1'b1;
          shift_d = w_fifo_dout;
          bit_d   = '0;
          tx_d    = 1'b0;
        end
      end
      c_st_start: begin
        if (w_bit_end) begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = '0;
        end
      end
      c_st_data: begin
        if (w_bit_end) begin
          if (bit_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      c_st_stop: begin
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop   = 1'b1;
            shift_d = w_fifo_dout;
            bit_d   = '0;
            tx_d    = 1'b0;
          end else begin
            tx_d = 1'b1;
          end
        end
      end
      default: begin
        cnt_d = '0;
        tx_d  = 1'b1;
      end
    endcase
  end

  assign tx_ready = ~w_full;
  assign UART_TX  = tx_q;
  assign tx_busy  = (state_q != c_st_idle) | ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_transmitter : scoreboard bench with a serial-line monitor
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_transmitter;

  localparam int unsigned CLK_FREQ = 1050;
  localparam int unsigned BAUD     = 100;
  localparam int DIV   = 10;         // 1050/100 truncated
  localparam int FRAME = 10 * DIV;

  logic       sysclk   = 1'b0;
  logic       reset    = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, UART_TX, tx_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;
  logic [7:0] exp_q[$];
  int starts[$];

  uart_transmitter #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (4)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .UART_TX  (UART_TX),
    .tx_busy  (tx_busy)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Line monitor: decodes each frame, insists every bit is stable for DIV cycles.
  initial begin : monitor
    logic [9:0] fr;
    logic       v;
    bit         stable, aborted;
    v = 1'b1;
    forever begin
      @(negedge sysclk);
      if (reset === 1'b1 && UART_TX === 1'b0) begin
        starts.push_back(cyc);
        stable  = 1'b1;
        aborted = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < DIV; k++) begin
            if (b != 0 || k != 0) @(negedge sysclk);
            if (reset !== 1'b1) begin aborted = 1'b1; break; end
            if (k == 0) v = UART_TX;
            else if (UART_TX !== v) stable = 1'b0;
          end
          if (aborted) break;
          fr[b] = v;
        end
        if (!aborted) begin
          check("bit_width", {31'b0, stable}, 1);
          check("start_bit", {31'b0, fr[0]}, 0);
          check("stop_bit", {31'b0, fr[9]}, 1);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got byte %0d, required no frame", fr[8:1]);
          end else begin
            check("rx_byte", {24'b0, fr[8:1]}, {24'b0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  // Called just after a rising edge; holds tx_valid until the byte is taken.
  task automatic send(input logic [7:0] b, output int tries);
    logic r;
    tries    = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    forever begin
      @(negedge sysclk);
      r = tx_ready;
      tries++;
      @(posedge sysclk);
      #1;
      if (r) begin
        exp_q.push_back(b);
        last_acc = cyc;
        break;
      end
      if (tries > 4 * FRAME) begin
        total++;
        bad++;
        $display("FAIL send_timeout: byte %0d not accepted after %0d cycles, required acceptance", b, tries);
        break;
      end
    end
  endtask

  task automatic wait_fall(output int c);
    int n;
    n = 0;
    c = -1;
    forever begin
      @(negedge sysclk);
      n++;
      if (tx_busy === 1'b0) begin c = cyc; break; end
      if (n > 8 * FRAME) begin
        total++;
        bad++;
        $display("FAIL busy_timeout: tx_busy still %0d after %0d cycles, required 0", tx_busy, n);
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int c;
    wait_fall(c);
    repeat (2) @(negedge sysclk);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int         tries, tries5, a, fall, n0, n1, t0, n;
    logic [7:0] tbl[6];
    logic [7:0] rnd_tbl[6];

    // Reset values
    repeat (3) @(negedge sysclk);
    check("rst_uart_tx", {31'b0, UART_TX}, 1);
    check("rst_tx_ready", {31'b0, tx_ready}, 1);
    check("rst_tx_busy", {31'b0, tx_busy}, 0);
    reset = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;

    // Single frame 0x54 with latency and end-of-stop timing
    send(8'h54, tries);
    a = last_acc;
    tx_valid = 1'b0;
    @(negedge sysclk);
    check("latency_pre", {31'b0, UART_TX}, 1);
    @(negedge sysclk);
    check("latency_start", {31'b0, UART_TX}, 0);
    wait_fall(fall);
    check("busy_fall_cycle", fall - a, 1 + FRAME);

    // Back-to-back 0x54, 0x0C
    @(posedge sysclk);
    #1;
    n0 = starts.size();
    send(8'h54, tries);
    send(8'h0C, tries);
    check("b2b_second_accept", tries, 1);
    tx_valid = 1'b0;
    wait_fall(fall);
    check("b2b_frames", starts.size() - n0, 2);
    if (starts.size() - n0 == 2) begin
      check("b2b_gap", starts[n0+1] - starts[n0], FRAME);
      check("b2b_total", fall - starts[n0], 2 * FRAME);
    end

    // Six bytes held back-to-back into an idle line: five fit, sixth retries
    tbl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    @(posedge sysclk);
    #1;
    for (int i = 0; i < 5; i++) begin
      send(tbl[i], tries);
      check("accept_first_try", tries, 1);
    end
    tx_data = tbl[5];
    @(negedge sysclk);
    check("full_ready_low", {31'b0, tx_ready}, 0);
    @(posedge sysclk);
    #1;
    send(tbl[5], tries5);
    check("sixth_retried", {31'b0, tries5 > 1}, 1);
    tx_valid = 1'b0;
    wait_idle();

    // Reset during data bit 3 of 0xA5 with 0x3C buffered
    @(posedge sysclk);
    #1;
    n0 = starts.size();
    send(8'hA5, tries);
    send(8'h3C, tries);
    tx_valid = 1'b0;
    n = 0;
    while (starts.size() == n0 && n < 3 * FRAME) begin
      @(negedge sysclk);
      n++;
    end
    check("abort_frame_started", {31'b0, starts.size() > n0}, 1);
    if (starts.size() > n0) begin
      t0 = starts[n0];
      while (cyc < t0 + 4 * DIV + DIV / 2) @(negedge sysclk);
      check("pre_reset_bit3", {31'b0, UART_TX}, 0);
      #1;
      reset = 1'b0;
      exp_q.delete();
      #1;
      check("abort_uart_tx", {31'b0, UART_TX}, 1);
      check("abort_tx_ready", {31'b0, tx_ready}, 1);
      check("abort_tx_busy", {31'b0, tx_busy}, 0);
      repeat (3) @(negedge sysclk);
      reset = 1'b1;
      n1 = starts.size();
      repeat (3 * FRAME) @(negedge sysclk);
      check("no_residual_frames", starts.size() - n1, 0);
      check("post_reset_idle_busy", {31'b0, tx_busy}, 0);
    end

    // Fresh frame after reset release
    @(posedge sysclk);
    #1;
    n0 = starts.size();
    send(8'h96, tries);
    a = last_acc;
    tx_valid = 1'b0;
    wait_fall(fall);
    check("fresh_frame_len", fall - a, 1 + FRAME);

    // Loopback-style traffic with random gaps
    rnd_tbl = '{8'h00, 8'hFF, 8'h81, 8'h7E, 8'hC3, 8'h5A};
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 2 * FRAME)) @(posedge sysclk);
      #1;
      send(rnd_tbl[i], tries);
      tx_valid = 1'b0;
    end
    wait_idle();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
